// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants for the PS/2 mouse protocol engine.
//   - state encodings (5-bit, exported on current_state for debug)
//   - host command and device response byte values
//   - init command list indices and a lookup helper
package ps2_pkg;

  localparam logic [4:0] ST_INIT       = 5'd0;
  localparam logic [4:0] ST_SEND       = 5'd1;
  localparam logic [4:0] ST_WAIT_SENT  = 5'd2;
  localparam logic [4:0] ST_WAIT_ACK   = 5'd3;
  localparam logic [4:0] ST_WAIT_BAT   = 5'd4;
  localparam logic [4:0] ST_WAIT_DEVID = 5'd5;
  localparam logic [4:0] ST_WAIT_ID    = 5'd6;
  localparam logic [4:0] ST_CFG_DONE   = 5'd7;
  localparam logic [4:0] ST_PKT0       = 5'd8;
  localparam logic [4:0] ST_PKT1       = 5'd9;
  localparam logic [4:0] ST_PKT2       = 5'd10;
  localparam logic [4:0] ST_PKT3       = 5'd11;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_GET_ID   = 8'hF2;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  localparam logic [7:0] ACK      = 8'hFA;
  localparam logic [7:0] BAT_OK   = 8'hAA;
  localparam logic [7:0] ID_STD   = 8'h00;
  localparam logic [7:0] ID_WHEEL = 8'h03;

  // Index layout of the init list: 0 reset, 1..7 IntelliMouse knock
  // sequence ending in GET_ID, 8..9 final sample rate, 10 enable.
  localparam logic [3:0] IDX_GET_ID = 4'd7;
  localparam logic [3:0] IDX_RATE   = 4'd8;
  localparam logic [3:0] IDX_LAST   = 4'd10;

  function automatic logic [7:0] init_cmd(input logic [3:0] idx, input logic [7:0] rate);
    case (idx)
      4'd0:    init_cmd = CMD_RESET;
      4'd1:    init_cmd = CMD_SET_RATE;
      4'd2:    init_cmd = 8'hC8;
      4'd3:    init_cmd = CMD_SET_RATE;
      4'd4:    init_cmd = 8'h64;
      4'd5:    init_cmd = CMD_SET_RATE;
      4'd6:    init_cmd = 8'h50;
      4'd7:    init_cmd = CMD_GET_ID;
      4'd8:    init_cmd = CMD_SET_RATE;
      4'd9:    init_cmd = rate;
      default: init_cmd = CMD_ENABLE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_pos_accum.sv
// ps2_pos_accum: one axis of the absolute cursor position.
//   pos     - current position
//   sign    - delta sign bit from packet byte 0
//   mag     - delta low byte (packet byte 1 or 2)
//   ovf     - axis overflow flag; forces the delta to zero
//   pos_nxt - pos + delta clamped to [0, LIMIT-1]
module ps2_pos_accum #(
  parameter int LIMIT = 160,
  parameter int POS_W = 8
) (
  input  logic [POS_W-1:0] pos,
  input  logic             sign,
  input  logic [7:0]       mag,
  input  logic             ovf,
  output logic [POS_W-1:0] pos_nxt
);
  // Two guard bits above the position keep pos+delta from wrapping;
  // never narrower than the 9-bit delta plus a sign bit.
  localparam int SW = (POS_W + 2 < 10) ? 10 : POS_W + 2;

  logic [8:0]    delta;
  logic [SW-1:0] sum;

  assign delta = ovf ? 9'd0 : {sign, mag};
  assign sum   = {{(SW-POS_W){1'b0}}, pos} + {{(SW-9){delta[8]}}, delta};

  always_comb begin
    pos_nxt = sum[POS_W-1:0];
    if (sum[SW-1])                        pos_nxt = '0;
    else if (sum > SW'(LIMIT - 1))        pos_nxt = POS_W'(LIMIT - 1);
  end

endmodule

// File: rtl/ps2_mouse_engine.sv
// ps2_mouse_engine: PS/2 mouse master protocol engine.
//   Runs the reset/init command list (optional IntelliMouse wheel detect),
//   decodes 3- or 4-byte stream packets, keeps a clamped absolute cursor
//   position and restarts on bad replies or a watchdog timeout.
// Ports:
//   CLK, RESET (sync, active low)
//   SEND_BYTE/BYTE_TO_SEND/BYTE_SENT          - transmitter handshake
//   READ_ENABLE/BYTE_READ/BYTE_ERROR_CODE/BYTE_READY - receiver handshake
//   MOUSE_STATUS/DX/DY/DZ, MOUSE_X/Y          - decoded packet, position
//   WHEEL_MODE, SEND_INTERRUPT, current_state - mode, packet pulse, debug
module ps2_mouse_engine
  import ps2_pkg::*;
#(
  parameter int LIMIT_X        = 160,
  parameter int LIMIT_Y        = 120,
  parameter int POS_W          = 8,
  parameter bit WHEEL_EN       = 1'b1,
  parameter int SAMPLE_RATE    = 100,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic             SEND_BYTE,
  output logic [7:0]       BYTE_TO_SEND,
  input  logic             BYTE_SENT,
  output logic             READ_ENABLE,
  input  logic [7:0]       BYTE_READ,
  input  logic [1:0]       BYTE_ERROR_CODE,
  input  logic             BYTE_READY,
  output logic [7:0]       MOUSE_STATUS,
  output logic [7:0]       MOUSE_DX,
  output logic [7:0]       MOUSE_DY,
  output logic [3:0]       MOUSE_DZ,
  output logic [POS_W-1:0] MOUSE_X,
  output logic [POS_W-1:0] MOUSE_Y,
  output logic             WHEEL_MODE,
  output logic             SEND_INTERRUPT,
  output logic [4:0]       current_state
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [4:0]       state, state_n;
  logic [3:0]       idx;
  logic [7:0]       b0, b1, b2;
  logic [WD_W-1:0]  wd_cnt;
  logic             wd_run, timeout, rd_ok, done;
  logic [7:0]       dy_mag;
  logic [POS_W-1:0] x_nxt, y_nxt;

  assign rd_ok   = BYTE_READY && (BYTE_ERROR_CODE == 2'd0);
  assign wd_run  = (state == ST_WAIT_SENT) || (state == ST_WAIT_ACK) ||
                   (state == ST_WAIT_BAT)  || (state == ST_WAIT_DEVID) ||
                   (state == ST_WAIT_ID)   || (state == ST_PKT1) ||
                   (state == ST_PKT2)      || (state == ST_PKT3);
  // A handshake in the expiry cycle takes priority over the timeout.
  assign timeout = wd_run && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) &&
                   !BYTE_READY && !BYTE_SENT;
  assign done    = rd_ok && (((state == ST_PKT2) && !WHEEL_MODE) || (state == ST_PKT3));
  // In 3-byte mode the Y byte is still on BYTE_READ when the packet completes.
  assign dy_mag  = (state == ST_PKT2) ? BYTE_READ : b2;

  assign READ_ENABLE   = (state == ST_WAIT_ACK) || (state == ST_WAIT_BAT) ||
                         (state == ST_WAIT_DEVID) || (state == ST_WAIT_ID) ||
                         (state == ST_PKT0) || (state == ST_PKT1) ||
                         (state == ST_PKT2) || (state == ST_PKT3);
  assign current_state = state;

  always_comb begin
    state_n = state;
    case (state)
      ST_INIT:      state_n = ST_SEND;
      ST_SEND:      state_n = ST_WAIT_SENT;
      ST_WAIT_SENT: if (BYTE_SENT) state_n = ST_WAIT_ACK;
                    else if (timeout) state_n = ST_INIT;
      ST_WAIT_ACK:
        if (BYTE_READY) begin
          if (!(rd_ok && BYTE_READ == ACK)) state_n = ST_INIT;
          else if (idx == 4'd0)             state_n = ST_WAIT_BAT;
          else if (idx == IDX_GET_ID)       state_n = ST_WAIT_ID;
          else if (idx == IDX_LAST)         state_n = ST_CFG_DONE;
          else                              state_n = ST_SEND;
        end else if (timeout) state_n = ST_INIT;
      ST_WAIT_BAT:
        if (BYTE_READY) state_n = (rd_ok && BYTE_READ == BAT_OK) ? ST_WAIT_DEVID : ST_INIT;
        else if (timeout) state_n = ST_INIT;
      ST_WAIT_DEVID:
        if (BYTE_READY) state_n = (rd_ok && BYTE_READ == ID_STD) ? ST_SEND : ST_INIT;
        else if (timeout) state_n = ST_INIT;
      ST_WAIT_ID:
        if (BYTE_READY)
          state_n = (rd_ok && (BYTE_READ == ID_WHEEL || BYTE_READ == ID_STD)) ? ST_SEND : ST_INIT;
        else if (timeout) state_n = ST_INIT;
      ST_CFG_DONE:  state_n = ST_PKT0;
      // Bytes without the always-one bit 3 are dropped to regain framing.
      ST_PKT0:      if (rd_ok && BYTE_READ[3]) state_n = ST_PKT1;
      ST_PKT1:      if (BYTE_READY) state_n = rd_ok ? ST_PKT2 : ST_PKT0;
                    else if (timeout) state_n = ST_INIT;
      ST_PKT2:      if (BYTE_READY) state_n = (rd_ok && WHEEL_MODE) ? ST_PKT3 : ST_PKT0;
                    else if (timeout) state_n = ST_INIT;
      ST_PKT3:      if (BYTE_READY) state_n = ST_PKT0;
                    else if (timeout) state_n = ST_INIT;
      default:      state_n = ST_INIT;
    endcase
  end

  ps2_pos_accum #(.LIMIT(LIMIT_X), .POS_W(POS_W)) u_acc_x (
    .pos(MOUSE_X), .sign(b0[4]), .mag(b1), .ovf(b0[6]), .pos_nxt(x_nxt));
  ps2_pos_accum #(.LIMIT(LIMIT_Y), .POS_W(POS_W)) u_acc_y (
    .pos(MOUSE_Y), .sign(b0[5]), .mag(dy_mag), .ovf(b0[7]), .pos_nxt(y_nxt));

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state          <= ST_INIT;
      idx            <= '0;
      wd_cnt         <= '0;
      b0             <= '0;
      b1             <= '0;
      b2             <= '0;
      SEND_BYTE      <= 1'b0;
      BYTE_TO_SEND   <= '0;
      MOUSE_STATUS   <= '0;
      MOUSE_DX       <= '0;
      MOUSE_DY       <= '0;
      MOUSE_DZ       <= '0;
      MOUSE_X        <= POS_W'(LIMIT_X / 2);
      MOUSE_Y        <= POS_W'(LIMIT_Y / 2);
      WHEEL_MODE     <= 1'b0;
      SEND_INTERRUPT <= 1'b0;
    end else begin
      state          <= state_n;
      SEND_BYTE      <= 1'b0;
      SEND_INTERRUPT <= done;

      if (!wd_run || state_n != state || BYTE_READY || BYTE_SENT) wd_cnt <= '0;
      else                                                        wd_cnt <= wd_cnt + WD_W'(1);

      if (state == ST_INIT) begin
        idx        <= '0;
        WHEEL_MODE <= 1'b0;
      end
      if (state == ST_SEND) begin
        SEND_BYTE    <= 1'b1;
        BYTE_TO_SEND <= init_cmd(idx, 8'(SAMPLE_RATE));
      end
      if (state_n == ST_SEND) begin
        if (state == ST_WAIT_ACK)   idx <= idx + 4'd1;
        if (state == ST_WAIT_DEVID) idx <= WHEEL_EN ? 4'd1 : IDX_RATE;
        if (state == ST_WAIT_ID) begin
          idx        <= IDX_RATE;
          WHEEL_MODE <= (BYTE_READ == ID_WHEEL);
        end
      end

      if (state == ST_PKT0 && state_n == ST_PKT1) b0 <= BYTE_READ;
      if (state == ST_PKT1 && state_n == ST_PKT2) b1 <= BYTE_READ;
      if (state == ST_PKT2 && state_n == ST_PKT3) b2 <= BYTE_READ;

      if (done) begin
        MOUSE_STATUS <= b0;
        MOUSE_DX     <= b1;
        MOUSE_DY     <= dy_mag;
        MOUSE_DZ     <= (state == ST_PKT3) ? BYTE_READ[3:0] : 4'd0;
        MOUSE_X      <= x_nxt;
        MOUSE_Y      <= y_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_engine.sv
// Directed bench for ps2_mouse_engine: init (standard and wheel), packet
// decode, clamping, resync/error discard, bad-ack restart, watchdog and
// mid-packet reset.
module tb_ps2_mouse_engine;
  import ps2_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'd0;
  logic       BYTE_READY = 1'b0;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
  logic [3:0] MOUSE_DZ;
  logic [7:0] MOUSE_X, MOUSE_Y;
  logic       WHEEL_MODE, SEND_INTERRUPT;
  logic [4:0] current_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  ps2_mouse_engine #(
    .LIMIT_X(160), .LIMIT_Y(120), .POS_W(8), .WHEEL_EN(1'b1),
    .SAMPLE_RATE(100), .TIMEOUT_CYCLES(64)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
    .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY),
    .MOUSE_DZ(MOUSE_DZ), .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y),
    .WHEEL_MODE(WHEEL_MODE), .SEND_INTERRUPT(SEND_INTERRUPT),
    .current_state(current_state)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx(input logic [7:0] b, input logic [1:0] err);
    BYTE_READ = b; BYTE_ERROR_CODE = err; BYTE_READY = 1'b1;
    tick;
    BYTE_READY = 1'b0; BYTE_ERROR_CODE = 2'd0;
  endtask

  task automatic wait_send(input logic [7:0] exp);
    for (int i = 0; i < 20 && !SEND_BYTE; i++) tick;
    chk("send_seen", {31'd0, SEND_BYTE}, 32'd1);
    chk("cmd_byte", {24'd0, BYTE_TO_SEND}, {24'd0, exp});
    BYTE_SENT = 1'b1;
    tick;
    BYTE_SENT = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] exp);
    wait_send(exp);
    rx(ACK, 2'd0);
  endtask

  task automatic init_seq(input logic [7:0] id_reply);
    wait_send(8'hFF);
    rx(ACK, 2'd0); rx(BAT_OK, 2'd0); rx(ID_STD, 2'd0);
    do_cmd(8'hF3); do_cmd(8'hC8); do_cmd(8'hF3); do_cmd(8'h64);
    do_cmd(8'hF3); do_cmd(8'h50); do_cmd(8'hF2);
    rx(id_reply, 2'd0);
    do_cmd(8'hF3); do_cmd(8'd100); do_cmd(8'hF4);
    tick;
    chk("init_pkt0", {27'd0, current_state}, {27'd0, ST_PKT0});
  endtask

  // Checks the cycle right after the final byte, then that the pulse drops.
  task automatic chk_pkt(input string tag, input logic [7:0] st, input logic [7:0] dx,
                         input logic [7:0] dy, input logic [3:0] dz,
                         input logic [7:0] x, input logic [7:0] y);
    chk({tag, "_irq"}, {31'd0, SEND_INTERRUPT}, 32'd1);
    chk({tag, "_st"},  {24'd0, MOUSE_STATUS}, {24'd0, st});
    chk({tag, "_dx"},  {24'd0, MOUSE_DX}, {24'd0, dx});
    chk({tag, "_dy"},  {24'd0, MOUSE_DY}, {24'd0, dy});
    chk({tag, "_dz"},  {28'd0, MOUSE_DZ}, {28'd0, dz});
    chk({tag, "_x"},   {24'd0, MOUSE_X}, {24'd0, x});
    chk({tag, "_y"},   {24'd0, MOUSE_Y}, {24'd0, y});
    tick;
    chk({tag, "_irq_off"}, {31'd0, SEND_INTERRUPT}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, {27'd0, current_state}, {27'd0, ST_INIT});
    chk({tag, "_x"}, {24'd0, MOUSE_X}, 32'd80);
    chk({tag, "_y"}, {24'd0, MOUSE_Y}, 32'd60);
    chk({tag, "_outs"}, {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, 4'd0, MOUSE_DZ}, 32'd0);
    chk({tag, "_flags"}, {28'd0, SEND_BYTE, READ_ENABLE, WHEEL_MODE, SEND_INTERRUPT}, 32'd0);
  endtask

  initial begin
    // Reset state
    tick; tick;
    chk_reset_vals("rst");
    chk("rst_cmd", {24'd0, BYTE_TO_SEND}, 32'd0);

    // First 0xFF appears two edges after release
    RESET = 1'b1;
    tick;
    chk("first_send_early", {31'd0, SEND_BYTE}, 32'd0);

    // Standard mouse init (ID 0x00)
    init_seq(ID_STD);
    chk("std_wheel", {31'd0, WHEEL_MODE}, 32'd0);
    chk("std_rden", {31'd0, READ_ENABLE}, 32'd1);

    // 08,05,03 -> X=85, Y=63
    rx(8'h08, 2'd0); rx(8'h05, 2'd0); rx(8'h03, 2'd0);
    chk_pkt("p1", 8'h08, 8'h05, 8'h03, 4'h0, 8'd85, 8'd63);

    // dx=-100 from 85 clamps to 0; +200 clamps to 159 twice
    rx(8'h18, 2'd0); rx(8'h9C, 2'd0); rx(8'h00, 2'd0);
    chk_pkt("clamp_lo", 8'h18, 8'h9C, 8'h00, 4'h0, 8'd0, 8'd63);
    rx(8'h08, 2'd0); rx(8'hC8, 2'd0); rx(8'h00, 2'd0);
    chk_pkt("clamp_hi1", 8'h08, 8'hC8, 8'h00, 4'h0, 8'd159, 8'd63);
    rx(8'h08, 2'd0); rx(8'hC8, 2'd0); rx(8'h00, 2'd0);
    chk_pkt("clamp_hi2", 8'h08, 8'hC8, 8'h00, 4'h0, 8'd159, 8'd63);

    // Resync: byte without bit 3 dropped; error mid-packet discards
    rx(8'h00, 2'd0);
    chk("resync_pkt0", {27'd0, current_state}, {27'd0, ST_PKT0});
    rx(8'h08, 2'd0);
    chk("resync_pkt1", {27'd0, current_state}, {27'd0, ST_PKT1});
    rx(8'h55, 2'd1);
    chk("err_pkt0", {27'd0, current_state}, {27'd0, ST_PKT0});
    chk("err_noirq", {31'd0, SEND_INTERRUPT}, 32'd0);
    rx(8'h18, 2'd0); rx(8'hFF, 2'd0); rx(8'h01, 2'd0);
    chk_pkt("after_err", 8'h18, 8'hFF, 8'h01, 4'h0, 8'd158, 8'd64);

    // X overflow bit zeroes dx; Y still moves
    rx(8'h48, 2'd0); rx(8'h10, 2'd0); rx(8'h02, 2'd0);
    chk_pkt("ovf_x", 8'h48, 8'h10, 8'h02, 4'h0, 8'd158, 8'd66);

    // Watchdog: stall in PKT1
    rx(8'h08, 2'd0);
    for (int i = 0; i < 60; i++) tick;
    chk("wd_not_yet", {27'd0, current_state}, {27'd0, ST_PKT1});
    for (int i = 0; i < 20 && current_state != ST_INIT; i++) tick;
    chk("wd_restart", {27'd0, current_state}, {27'd0, ST_INIT});
    chk("wd_keep_x", {24'd0, MOUSE_X}, 32'd158);
    chk("wd_keep_y", {24'd0, MOUSE_Y}, 32'd66);

    // Bad ack to 0xFF restarts; 0xFF is resent by init_seq
    wait_send(8'hFF);
    rx(8'hFE, 2'd0);
    chk("nak_restart", {27'd0, current_state}, {27'd0, ST_INIT});

    // Wheel mouse init (ID 0x03) and a 4-byte packet
    init_seq(ID_WHEEL);
    chk("wheel_mode", {31'd0, WHEEL_MODE}, 32'd1);
    rx(8'h08, 2'd0); rx(8'h00, 2'd0); rx(8'h00, 2'd0);
    chk("wheel_pkt3", {27'd0, current_state}, {27'd0, ST_PKT3});
    chk("wheel_noirq3", {31'd0, SEND_INTERRUPT}, 32'd0);
    rx(8'h0F, 2'd0);
    chk_pkt("wheel", 8'h08, 8'h00, 8'h00, 4'hF, 8'd158, 8'd66);

    // Reset during PKT2
    rx(8'h08, 2'd0); rx(8'h05, 2'd0);
    chk("mid_pkt2", {27'd0, current_state}, {27'd0, ST_PKT2});
    RESET = 1'b0;
    tick;
    chk_reset_vals("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
